// File: rtl/f_pc_ctrl_pkg.sv
// rtl/f_pc_ctrl_pkg.sv - shared widths, state encodings and BTB prediction helper for f_pc_ctrl
package f_pc_ctrl_pkg;

  localparam int PC_W        = 13;
  localparam int BTB_IDX_W   = 11;
  localparam int BTB_ENTRY_W = 16;
  localparam int BTB_DEPTH   = 1 << BTB_IDX_W;
  localparam int WBUF_W      = BTB_IDX_W + BTB_ENTRY_W;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  typedef enum logic [1:0] {
    S_CLEAR = ST_CLEAR,
    S_PRIME = ST_PRIME,
    S_RUN   = ST_RUN,
    S_FLUSH = ST_FLUSH
  } state_t;

  // Entry is {valid, tag = pc[12:11], target}; a tag mismatch falls through to pc+1.
  function automatic logic [PC_W-1:0] predict(input logic [BTB_ENTRY_W-1:0] entry,
                                               input logic [PC_W-1:0]        cur);
    if (entry[15] && (entry[14:13] == cur[12:11]))
      return entry[12:0];
    return cur + PC_W'(1);
  endfunction

endpackage

// File: rtl/f_pc_ctrl_btb_wbuf.sv
// rtl/f_pc_ctrl_btb_wbuf.sv - synchronous FIFO holding pending BTB updates {addr, data}
module btb_wbuf
  import f_pc_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WBUF_W-1:0] push_data,
  input  logic              pop,
  output logic [WBUF_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WBUF_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  // A push into a full buffer is legal when a pop frees a slot in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != (PTR_W+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/f_pc_ctrl.sv
// rtl/f_pc_ctrl.sv - fetch-PC sequencer and single-port BTB arbiter
// Optional F_PC_CTRL_PERF_EN adds mispredict_cnt/drop_cnt saturating counters.
module f_pc_ctrl
  import f_pc_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = 13'h0000,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              WBUF_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   e_fail_predict,
  input  logic [PC_W-1:0]        e_nextpc,
  input  logic                   e_wen,
  input  logic [BTB_IDX_W-1:0]   e_w_addr,
  input  logic [BTB_ENTRY_W-1:0] e_w_data,
  output logic [PC_W-1:0]        pc,
  output logic [PC_W-1:0]        pc_predicted,
  output logic                   flush,
  output logic                   wbuf_full
`ifdef F_PC_CTRL_PERF_EN
  ,
  output logic [31:0]            mispredict_cnt,
  output logic [31:0]            drop_cnt
`endif
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t                 state;
  state_t                 state_nxt;
  logic [BTB_IDX_W-1:0]   clr_idx;
  logic [FC_W-1:0]        flush_cnt;
  logic [BTB_ENTRY_W-1:0] btb_q;
  logic [BTB_ENTRY_W-1:0] btb_mem [BTB_DEPTH];

  logic                   mem_we;
  logic                   mem_re;
  logic [BTB_IDX_W-1:0]   mem_addr;
  logic [BTB_ENTRY_W-1:0] mem_wdata;
  logic                   pc_load;
  logic [PC_W-1:0]        pc_nxt;
  logic                   port_free;
  logic                   redirect;
  logic                   direct_wr;
  logic                   dropped;

  logic                   wb_push;
  logic                   wb_pop;
  logic [WBUF_W-1:0]      wb_head;
  logic                   wb_full;
  logic                   wb_empty;

  btb_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (wb_push),
    .push_data ({e_w_addr, e_w_data}),
    .pop       (wb_pop),
    .pop_data  (wb_head),
    .full      (wb_full),
    .empty     (wb_empty)
  );

  assign pc_predicted = predict(btb_q, pc);
  assign flush        = (state != S_RUN);
  assign wbuf_full    = wb_full;

  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  // Port priority: clear write, then fetch read, then update write (direct or drained).
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pc_load   = 1'b0;
    pc_nxt    = pc;
    port_free = 1'b0;
    redirect  = 1'b0;
    case (state)
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_idx;
        if (clr_idx == '1) state_nxt = S_PRIME;
      end
      S_PRIME: begin
        mem_re    = 1'b1;
        mem_addr  = RESET_PC[BTB_IDX_W-1:0];
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (e_fail_predict) begin
          redirect  = 1'b1;
          mem_re    = 1'b1;
          mem_addr  = e_nextpc[BTB_IDX_W-1:0];
          pc_load   = 1'b1;
          pc_nxt    = e_nextpc;
          state_nxt = S_FLUSH;
        end else if (!stall) begin
          mem_re   = 1'b1;
          mem_addr = pc_predicted[BTB_IDX_W-1:0];
          pc_load  = 1'b1;
          pc_nxt   = pc_predicted;
        end else begin
          port_free = 1'b1;
        end
      end
      S_FLUSH: begin
        port_free = 1'b1;
        if (flush_cnt == '0) state_nxt = S_RUN;
      end
      default: state_nxt = S_CLEAR;
    endcase

    direct_wr = e_wen && port_free && wb_empty;
    wb_pop    = port_free && !wb_empty;
    wb_push   = e_wen && !direct_wr && (!wb_full || wb_pop);
    dropped   = e_wen && !direct_wr && wb_full && !wb_pop;

    if (direct_wr) begin
      mem_we    = 1'b1;
      mem_addr  = e_w_addr;
      mem_wdata = e_w_data;
    end else if (wb_pop) begin
      mem_we    = 1'b1;
      mem_addr  = wb_head[WBUF_W-1:BTB_ENTRY_W];
      mem_wdata = wb_head[BTB_ENTRY_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      clr_idx   <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == S_CLEAR) clr_idx <= clr_idx + BTB_IDX_W'(1);
      if (pc_load) pc <= pc_nxt;
      if (redirect)
        flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
      else if ((state == S_FLUSH) && (flush_cnt != '0))
        flush_cnt <= flush_cnt - FC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) btb_mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)         btb_q <= '0;
    else if (mem_re) btb_q <= btb_mem[mem_addr];
  end

`ifdef F_PC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_cnt <= '0;
      drop_cnt       <= '0;
    end else begin
      if (redirect && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 32'd1;
      if (dropped && (drop_cnt != '1))        drop_cnt       <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_f_pc_ctrl.sv
// tb/tb_f_pc_ctrl.sv - scoreboard bench for f_pc_ctrl (F_PC_CTRL_PERF_EN optional)
module tb_f_pc_ctrl;

  localparam int SIG_PC   = 0;
  localparam int SIG_PRED = 1;
  localparam int SIG_FLSH = 2;
  localparam int SIG_FULL = 3;
  localparam int SIG_MISP = 4;
  localparam int SIG_DROP = 5;

  typedef struct {
    int          at;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        e_fail_predict;
  logic [12:0] e_nextpc;
  logic        e_wen;
  logic [10:0] e_w_addr;
  logic [15:0] e_w_data;
  logic [12:0] pc;
  logic [12:0] pc_predicted;
  logic        flush;
  logic        wbuf_full;
`ifdef F_PC_CTRL_PERF_EN
  logic [31:0] mispredict_cnt;
  logic [31:0] drop_cnt;
`endif

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb [$];

  f_pc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .e_fail_predict (e_fail_predict),
    .e_nextpc       (e_nextpc),
    .e_wen          (e_wen),
    .e_w_addr       (e_w_addr),
    .e_w_data       (e_w_data),
    .pc             (pc),
    .pc_predicted   (pc_predicted),
    .flush          (flush),
    .wbuf_full      (wbuf_full)
`ifdef F_PC_CTRL_PERF_EN
    ,
    .mispredict_cnt (mispredict_cnt),
    .drop_cnt       (drop_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(int sig);
    case (sig)
      SIG_PC:   return {19'd0, pc};
      SIG_PRED: return {19'd0, pc_predicted};
      SIG_FLSH: return {31'd0, flush};
      SIG_FULL: return {31'd0, wbuf_full};
`ifdef F_PC_CTRL_PERF_EN
      SIG_MISP: return mispredict_cnt;
      SIG_DROP: return drop_cnt;
`endif
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Expectations are kept ordered by target cycle so the monitor pops strictly in time order.
  task automatic expect_at(int d, int sig, logic [31:0] val, string name);
    exp_t e;
    int   i;
    e.at = cyc + d; e.sig = sig; e.val = val; e.name = name;
    i = sb.size();
    while (i > 0 && sb[i-1].at > e.at) i--;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e   = sb.pop_front();
      act = get_sig(e.sig);
      n_cmp++;
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s @cyc %0d: got %0h, expected %0h", e.name, cyc, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; e_fail_predict = 1'b0; e_nextpc = '0;
    e_wen = 1'b0; e_w_addr = '0; e_w_data = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state and the power-on clear sweep
    expect_at(0, SIG_PC, 0, "rst_pc");
    expect_at(0, SIG_PRED, 1, "rst_pred");
    expect_at(0, SIG_FLSH, 1, "rst_flush");
    expect_at(0, SIG_FULL, 0, "rst_wbuf_full");
`ifdef F_PC_CTRL_PERF_EN
    expect_at(0, SIG_MISP, 0, "rst_misp_cnt");
    expect_at(0, SIG_DROP, 0, "rst_drop_cnt");
`endif
    for (int d = 1; d <= 2048; d++) expect_at(d, SIG_FLSH, 1, "clear_flush");
    expect_at(2048, SIG_PC, 0, "clear_pc_hold");
    expect_at(2049, SIG_FLSH, 0, "run_flush_low");
    expect_at(2049, SIG_PC, 0, "run_pc");
    expect_at(2049, SIG_PRED, 1, "run_pred_cleared");
    repeat (2049) step();

    // Direct BTB write on a free port, then a tag hit at pc 0x010
    stall = 1'b1; e_wen = 1'b1; e_w_addr = 11'h010; e_w_data = 16'h8100;
    expect_at(1, SIG_PC, 0, "stall_hold");
    expect_at(1, SIG_FULL, 0, "direct_not_buffered");
    step();
    stall = 1'b0; e_wen = 1'b0;
    expect_at(1, SIG_PC, 1, "seq_pc1");
    expect_at(2, SIG_PC, 2, "seq_pc2");
    expect_at(16, SIG_PC, 13'h0010, "hit_pc");
    expect_at(16, SIG_PRED, 13'h0100, "hit_pred");
    expect_at(17, SIG_PC, 13'h0100, "hit_jump");
    repeat (17) step();

    // Redirect to 0x0810: tag 01 misses; mispredict during FLUSH ignored
    e_fail_predict = 1'b1; e_nextpc = 13'h0810;
    expect_at(1, SIG_PC, 13'h0810, "redir_pc");
    expect_at(1, SIG_PRED, 13'h0811, "tag_miss_pred");
    expect_at(1, SIG_FLSH, 1, "redir_flush1");
    expect_at(2, SIG_FLSH, 1, "redir_flush2");
    expect_at(2, SIG_PC, 13'h0810, "flush_ignore_pc");
    expect_at(3, SIG_FLSH, 0, "redir_flush_end");
    expect_at(3, SIG_PC, 13'h0810, "flush_exit_pc");
    expect_at(4, SIG_PC, 13'h0811, "post_flush_pc");
    step();
    e_nextpc = 13'h1234;
    step();
    e_fail_predict = 1'b0;
    step(); step();

    // Get to pc 0x0020, then mispredict with stall=1 (mispredict wins)
    e_fail_predict = 1'b1; e_nextpc = 13'h0020;
    step();
    e_fail_predict = 1'b0;
    step(); step();
    expect_at(0, SIG_PC, 13'h0020, "pre_redirect_pc");
    stall = 1'b1; e_fail_predict = 1'b1; e_nextpc = 13'h0400;
    expect_at(1, SIG_PC, 13'h0400, "stall_redirect_pc");
    expect_at(1, SIG_FLSH, 1, "stall_redirect_flush1");
    expect_at(2, SIG_FLSH, 1, "stall_redirect_flush2");
    expect_at(2, SIG_PC, 13'h0400, "stall_redirect_hold");
    expect_at(3, SIG_FLSH, 0, "stall_redirect_end");
    expect_at(3, SIG_PC, 13'h0400, "stall_redirect_hold2");
    expect_at(4, SIG_PC, 13'h0401, "stall_redirect_next");
    step();
    stall = 1'b0; e_nextpc = 13'h1234;
    step();
    e_fail_predict = 1'b0;
    step(); step();
`ifdef F_PC_CTRL_PERF_EN
    expect_at(0, SIG_MISP, 3, "misp_cnt");
`endif

    // Buffer fill, drop when full, push-with-drain, oldest-first drain (last write wins)
    e_wen = 1'b1; e_w_addr = 11'h405; e_w_data = 16'h8AAA;
    expect_at(1, SIG_FULL, 0, "wbuf_one");
    step();
    e_w_data = 16'h8BBB;
    expect_at(1, SIG_FULL, 1, "wbuf_full");
    step();
    e_w_data = 16'h8CCC;
    expect_at(1, SIG_FULL, 1, "wbuf_full_drop");
`ifdef F_PC_CTRL_PERF_EN
    expect_at(1, SIG_DROP, 1, "drop_cnt");
`endif
    step();
    stall = 1'b1; e_w_data = 16'h8DDD;
    expect_at(1, SIG_FULL, 1, "full_push_with_pop");
    step();
    e_wen = 1'b0;
    expect_at(1, SIG_FULL, 0, "drain_second");
    step();
    expect_at(1, SIG_FULL, 0, "drain_third");
    step();
    stall = 1'b0;
    expect_at(0, SIG_PC, 13'h0404, "drain_stall_pc");
    expect_at(1, SIG_PC, 13'h0405, "drain_done_pc");
    expect_at(1, SIG_PRED, 13'h0DDD, "last_write_wins");
    expect_at(2, SIG_PC, 13'h0DDD, "last_write_jump");
    expect_at(2, SIG_PRED, 13'h0DDE, "tag01_miss");
`ifdef F_PC_CTRL_PERF_EN
    expect_at(2, SIG_DROP, 1, "drop_cnt_stable");
`endif
    step(); step();

    // pc wrap at 0x1FFF, then reset mid-FLUSH with a full buffer
    e_wen = 1'b1; e_w_addr = 11'h7F0; e_w_data = 16'h8123;
    step();
    e_fail_predict = 1'b1; e_nextpc = 13'h1FFF; e_w_data = 16'h8456;
    expect_at(1, SIG_PC, 13'h1FFF, "wrap_pc");
    expect_at(1, SIG_PRED, 13'h0000, "wrap_pred");
    expect_at(1, SIG_FULL, 1, "full_before_rst");
    expect_at(1, SIG_FLSH, 1, "flush_before_rst");
    step();
    rst = 1'b1; e_fail_predict = 1'b0; e_wen = 1'b0;
    expect_at(1, SIG_FLSH, 1, "rst2_flush");
    expect_at(1, SIG_FULL, 0, "rst2_empty");
    expect_at(1, SIG_PC, 0, "rst2_pc");
    expect_at(1, SIG_PRED, 1, "rst2_pred");
`ifdef F_PC_CTRL_PERF_EN
    expect_at(1, SIG_MISP, 0, "rst2_misp_cnt");
    expect_at(1, SIG_DROP, 0, "rst2_drop_cnt");
`endif
    step();
    rst = 1'b0;
    expect_at(2048, SIG_FLSH, 1, "clear2_flush");
    expect_at(2049, SIG_FLSH, 0, "clear2_done");
    expect_at(2049 + 16, SIG_PC, 13'h0010, "clear2_pc");
    expect_at(2049 + 16, SIG_PRED, 13'h0011, "clear2_entry_zero");
    repeat (2049 + 20) step();

    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      n_cmp += sb.size();
      n_err += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
